// File: rtl/fifo_serial_tx.sv
// FIFO read-side consumer: pops words and sends them as UART-style frames, LSB first.
// Define PARITY_EN to add a parity bit (even/odd chosen by PAR_TYPE) before the stop bit.
`timescale 1ns/1ps
module fifo_serial_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE   = 8,
   parameter int PAR_TYPE   = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic                  EMPTY,
   input  logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  R_INC,
   output logic                  TX_OUT,
   output logic                  BUSY
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [BW-1:0]         bit_cnt;
   logic [7:0]            pre_cnt;
   logic                  bit_end;
   logic                  last_bit;

   assign bit_end  = (pre_cnt == 8'(PRESCALE - 1));
   assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

`ifdef PARITY_EN
   logic parity_bit;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         parity_bit <= 1'b0;
      end else if (R_INC) begin
         parity_bit <= (^RD_DATA) ^ (PAR_TYPE != 0);
      end
   end
`else
   logic unused_par_type;
   assign unused_par_type = (PAR_TYPE != 0);
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // R_INC is gated by RST so a FIFO that is non-empty during reset is never popped.
   always_comb begin
      next_state = state;
      R_INC      = 1'b0;
      TX_OUT     = 1'b1;
      BUSY       = 1'b1;
      case (state)
         IDLE: begin
            BUSY = 1'b0;
            if (EN && !EMPTY && !RST) begin
               R_INC      = 1'b1;
               next_state = START;
            end
         end
         START: begin
            TX_OUT = 1'b0;
            if (bit_end) next_state = DATA;
         end
         DATA: begin
            TX_OUT = shift_reg[0];
            if (bit_end && last_bit) begin
`ifdef PARITY_EN
               next_state = PARITY;
`else
               next_state = STOP;
`endif
            end
         end
`ifdef PARITY_EN
         PARITY: begin
            TX_OUT = parity_bit;
            if (bit_end) next_state = STOP;
         end
`endif
         STOP: begin
            if (bit_end) next_state = IDLE;
         end
         default: begin
            BUSY       = 1'b0;
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         pre_cnt   <= '0;
      end else begin
         if (state == IDLE || bit_end) begin
            pre_cnt <= '0;
         end else begin
            pre_cnt <= pre_cnt + 8'd1;
         end
         if (R_INC) begin
            shift_reg <= RD_DATA;
         end else if (state == DATA && bit_end) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Scoreboard bench for fifo_serial_tx: a FIFO model feeds the DUT, a serial decoder checks frames.
// Honours PARITY_EN so the same bench covers both builds.
`timescale 1ns/1ps
module tb_fifo_serial_tx;

   localparam int DW  = 8;
   localparam int PRE = 4;
   localparam int PAR = 0;
`ifdef PARITY_EN
   localparam int FRAME = PRE * (DW + 3);
`else
   localparam int FRAME = PRE * (DW + 2);
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          EN = 1'b1;
   logic          EMPTY = 1'b1;
   logic [DW-1:0] RD_DATA = '0;
   logic          R_INC;
   logic          TX_OUT;
   logic          BUSY;

   int            passed = 0;
   int            total = 0;
   int            cyc = 0;
   int            pops = 0;
   int            busy_len = 0;
   bit            rst_seen = 1'b0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int            pop_times[$];

   fifo_serial_tx #(.DATA_WIDTH(DW), .PRESCALE(PRE), .PAR_TYPE(PAR)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .EMPTY(EMPTY), .RD_DATA(RD_DATA),
      .R_INC(R_INC), .TX_OUT(TX_OUT), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual === expected) passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
   endtask

   task automatic refresh_fifo();
      EMPTY   = (fifo_q.size() == 0);
      RD_DATA = EMPTY ? '0 : fifo_q[0];
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      fifo_q.push_back(d);
      exp_q.push_back(d);
      refresh_fifo();
   endtask

   task automatic drive_point();
      @(negedge CLK);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(BUSY == 1'b0 && EMPTY == 1'b1) && n < 400) begin
         @(negedge CLK);
         n++;
      end
      check_output(name, (n >= 400), 0);
   endtask

   // FIFO model: the pop lands just after the edge on which the DUT latched the head word.
   always @(posedge CLK) begin
      cyc++;
      if (R_INC === 1'b1) begin
         pops++;
         pop_times.push_back(cyc);
         #1;
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         refresh_fifo();
      end
   end

   always @(posedge RST) rst_seen = 1'b1;

   always @(negedge CLK) begin
      if (R_INC === 1'b1) check_output("rinc_legal", {29'd0, BUSY, EMPTY, !EN}, 0);
      if (RST) busy_len = 0;
      else if (BUSY) busy_len++;
      else if (busy_len != 0) begin
         check_output("busy_len", busy_len, FRAME);
         busy_len = 0;
      end
   end

   // Decoder samples each bit cell two cycles in; a reset anywhere in the frame discards the word.
   task automatic decode_frame();
      logic [DW-1:0] got;
      logic [DW-1:0] exp;
      logic          par;
      bit            aborted;
      rst_seen = 1'b0;
      aborted  = 1'b0;
      got      = '0;
      par      = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check_output("start_bit", TX_OUT, 0);
      for (int i = 0; i < DW; i++) begin
         repeat (PRE) @(negedge CLK);
         if (rst_seen) begin
            aborted = 1'b1;
            break;
         end
         got[i] = TX_OUT;
      end
`ifdef PARITY_EN
      if (!aborted) begin
         repeat (PRE) @(negedge CLK);
         if (rst_seen) aborted = 1'b1;
         else par = TX_OUT;
      end
`endif
      if (!aborted) begin
         repeat (PRE) @(negedge CLK);
         if (rst_seen) aborted = 1'b1;
         else check_output("stop_bit", TX_OUT, 1);
      end
      if (exp_q.size() == 0) begin
         check_output("unexpected_frame", got, 'x);
      end else begin
         exp = exp_q.pop_front();
         if (aborted) begin
            $display("[TB] frame for word %h aborted by reset", exp);
         end else begin
            check_output("frame_data", got, exp);
`ifdef PARITY_EN
            check_output("parity_bit", par, (^exp) ^ PAR[0]);
`endif
         end
      end
   endtask

   always begin
      @(negedge TX_OUT);
      if (!RST) decode_frame();
   end

   task automatic apply_stimulus();
      int p;
      int n;
      bit tx_low;

      // Reset with a non-empty FIFO and EN high: idle outputs, no pop.
      push_word(8'h11);
      repeat (3) begin
         @(negedge CLK);
         check_output("rst_tx", TX_OUT, 1);
         check_output("rst_busy", BUSY, 0);
         check_output("rst_rinc", R_INC, 0);
      end
      check_output("rst_no_pop", pops, 0);
      drive_point();
      RST = 1'b0;
      wait_idle("idle_after_reset");
      check_output("pops_after_reset", pops, 1);

      // Single word: TX_OUT falls one clock after EMPTY falls.
      repeat (3) @(negedge CLK);
      #1;
      p = pops;
      push_word(8'hA5);
      @(posedge CLK);
      #1;
      check_output("start_latency", TX_OUT, 0);
      check_output("single_pop", pops, p + 1);
      wait_idle("idle_a5");
      check_output("one_pop_a5", pops, p + 1);

`ifdef PARITY_EN
      drive_point();
      push_word(8'hA5);
      push_word(8'h07);
      wait_idle("idle_parity");
`endif

      // Back-to-back drain of three preloaded words.
      drive_point();
      EN = 1'b0;
      push_word(8'h01);
      push_word(8'h80);
      push_word(8'hFF);
      n = pop_times.size();
      drive_point();
      EN = 1'b1;
      wait_idle("idle_burst");
      check_output("burst_pops", pop_times.size(), n + 3);
      if (pop_times.size() >= n + 3) begin
         check_output("period_1", pop_times[n+1] - pop_times[n], FRAME + 1);
         check_output("period_2", pop_times[n+2] - pop_times[n+1], FRAME + 1);
      end
      check_output("burst_busy", BUSY, 0);
      check_output("burst_empty", EMPTY, 1);

      // EN low holds off pops; EN dropped mid-frame lets the frame finish.
      drive_point();
      EN = 1'b0;
      push_word(8'h3C);
      push_word(8'hC3);
      p = pops;
      tx_low = 1'b0;
      repeat (20) begin
         @(negedge CLK);
         if (TX_OUT !== 1'b1) tx_low = 1'b1;
      end
      check_output("en_low_no_pop", pops, p);
      check_output("en_low_tx_high", tx_low, 0);
      drive_point();
      EN = 1'b1;
      @(posedge CLK);
      #1;
      check_output("en_start", TX_OUT, 0);
      repeat (12) @(negedge CLK);
      #1;
      EN = 1'b0;
      n = 0;
      while (BUSY && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check_output("frame_finish_timeout", (n >= 200), 0);
      repeat (20) @(negedge CLK);
      check_output("en_drop_one_pop", pops, p + 1);
      check_output("en_drop_fifo_kept", EMPTY, 0);
      #1;
      EN = 1'b1;
      @(posedge CLK);
      #1;
      check_output("en_resume", TX_OUT, 0);
      check_output("en_resume_pop", pops, p + 2);
      wait_idle("idle_en");

      // Reset during data bit 3 (a 0 bit of 0x52) aborts the frame at once.
      drive_point();
      push_word(8'h52);
      @(posedge CLK);
      repeat (17) @(negedge CLK);
      #1;
      check_output("pre_reset_bit3", TX_OUT, 0);
      RST = 1'b1;
      #1;
      check_output("abort_tx", TX_OUT, 1);
      check_output("abort_busy", BUSY, 0);
      check_output("abort_rinc", R_INC, 0);
      drive_point();
      RST = 1'b0;
      p = pops;
      repeat (20) @(negedge CLK);
      check_output("post_reset_no_pop", pops, p);
      check_output("post_reset_idle", BUSY, 0);
      #1;
      push_word(8'h69);
      wait_idle("idle_after_abort");
      check_output("post_reset_pop", pops, p + 1);
      repeat (5) @(negedge CLK);
      check_output("frames_pending", exp_q.size(), 0);
   endtask

   initial begin
      refresh_fifo();
      apply_stimulus();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
